// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 LSB-first data bits, optional parity, 1-2 stop bits.
// Every bit is held for div clocks; frame config is latched when the byte is accepted.
module uart_tx_serializer #(
    parameter int unsigned DIV_W      = 16,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       din_8b_i,
    input  logic             din_valid_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [1:0]       data_len_2b_i,
    input  logic             stop_2bit_i,
    input  logic             parity_en_i,
    input  logic [1:0]       parity_mode_2b_i,
    output logic             tx_o,
    output logic             tx_busy_o,
    output logic             overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx;
    logic             stop2_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic             stop_idx;
    logic             bit_last;

    // Parity over the low N = 5 + len bits only; upper bits of the byte are ignored.
    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] len,
                                         input logic [1:0] mode);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - len);
        x    = ^(d & mask);
        case (mode)
            2'd0:    calc_parity = ~x;
            2'd1:    calc_parity = x;
            2'd2:    calc_parity = 1'b0;
            default: calc_parity = 1'b1;
        endcase
    endfunction

    assign bit_last = (cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= DIV_W'(1);
            shreg     <= '0;
            bit_idx   <= '0;
            last_idx  <= '0;
            stop2_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_idx  <= 1'b0;
            tx_o      <= IDLE_LEVEL;
            tx_busy_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            // Any strobe while a frame is in flight is dropped and flagged.
            if (state != IDLE) begin
                overrun_o <= din_valid_i;
                cnt       <= bit_last ? '0 : cnt + DIV_W'(1);
            end
            case (state)
                IDLE: begin
                    if (din_valid_i) begin
                        shreg     <= din_8b_i;
                        div_q     <= (div_i == '0) ? DIV_W'(1) : div_i;
                        last_idx  <= 3'(3'd4 + 3'(data_len_2b_i));
                        stop2_q   <= stop_2bit_i;
                        par_en_q  <= parity_en_i;
                        par_bit_q <= calc_parity(din_8b_i, data_len_2b_i, parity_mode_2b_i);
                        cnt       <= '0;
                        tx_o      <= 1'b0;
                        tx_busy_o <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_last) begin
                        tx_o    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        if (bit_idx == last_idx) begin
                            if (par_en_q) begin
                                tx_o  <= par_bit_q;
                                state <= PARITY;
                            end else begin
                                tx_o     <= IDLE_LEVEL;
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_last) begin
                        tx_o     <= IDLE_LEVEL;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        if (stop2_q && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            tx_o      <= IDLE_LEVEL;
                            tx_busy_o <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_o      <= IDLE_LEVEL;
                    tx_busy_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
